ysyx_22040237_mcyc_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, decode, execute, memory and writeback, and owns the architectural PC. It gates the execute unit, the register-file write and the data-memory request. It stops the core permanently on `ebreak`, an invalid instruction or a misaligned jump target, and reports a halt code to the simulation harness.

---
 rtl/ysyx_22040237_pkg.sv | 21 ++
 rtl/ysyx_22040237_perf_cnt.sv | 34 +++
 rtl/ysyx_22040237_mcyc_ctrl.sv | 133 +++++++++++++
 tb/tb_ysyx_22040237_mcyc_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_pkg.sv
// Shared types and constants for the ysyx_22040237 multi-cycle control path:
// sequencer state encoding, halt codes and the default reset PC.
package ysyx_22040237_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] HALT_GOOD     = 2'd0;
  localparam logic [1:0] HALT_ABORT    = 2'd1;
  localparam logic [1:0] HALT_MISALIGN = 2'd2;

  localparam logic [31:0] YSYX_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22040237_perf_cnt.sv
// 64-bit cycle and retired-instruction counters. The module only exists when
// YSYX_22040237_PERF_EN is defined, so the default build carries no counter flops.
`ifdef YSYX_22040237_PERF_EN
module ysyx_22040237_perf_cnt
  import ysyx_22040237_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_cycle,
  input  logic        inc_instret,
  input  logic        freeze,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  logic [63:0] r_cycle;
  logic [63:0] r_instret;

  // freeze wins so both counts stay readable once the core has stopped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle   <= 64'd0;
      r_instret <= 64'd0;
    end else if (!freeze) begin
      if (inc_cycle)   r_cycle   <= r_cycle + 64'd1;
      if (inc_instret) r_instret <= r_instret + 64'd1;
    end
  end

  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;

endmodule
`endif

// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns the PC and steps each instruction
// through fetch/decode/execute/memory/writeback. Counters need YSYX_22040237_PERF_EN.
module ysyx_22040237_mcyc_ctrl
  import ysyx_22040237_pkg::*;
#(
  parameter logic [31:0] RESET_PC = YSYX_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        exu_en,
  input  logic        is_mem,
  input  logic        jump_en,
  input  logic [31:0] pc_jump_addr,
  input  logic        inst_ebreak,
  input  logic        invalid_inst,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  halt_code,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_jump_en;
  logic [31:0] r_jump_addr;
  logic        r_halted;
  logic [1:0]  r_halt_code;
  logic        w_misalign;
  logic        w_halt_req;
  logic [1:0]  w_halt_code;

  assign w_misalign = jump_en && (pc_jump_addr[1:0] != 2'b00);
  assign w_halt_req = invalid_inst || inst_ebreak || w_misalign;

  always_comb begin
    w_halt_code = HALT_MISALIGN;
    if (invalid_inst)     w_halt_code = HALT_ABORT;
    else if (inst_ebreak) w_halt_code = HALT_GOOD;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_rvalid) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_halt_req)  w_state_nxt = ST_HALT;
        else if (is_mem) w_state_nxt = ST_MEM;
        else             w_state_nxt = ST_WB;
      end
      ST_MEM:    if (dmem_ack) w_state_nxt = ST_WB;
      ST_WB:     w_state_nxt = ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // late rvalid/ack outside FETCH/MEM fall through the case below untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_jump_en   <= 1'b0;
      r_halted    <= 1'b0;
      r_halt_code <= HALT_GOOD;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
      case (r_state)
        ST_FETCH: if (imem_rvalid) r_inst <= imem_rdata;
        ST_EXEC: begin
          r_jump_en <= jump_en;
          if (w_halt_req) r_halt_code <= w_halt_code;
        end
        ST_WB:    r_pc <= r_jump_en ? r_jump_addr : r_pc + 32'd4;
        default:  ;
      endcase
    end
  end

  // redirect target is pure data; r_jump_en qualifies it
  always_ff @(posedge clk) begin
    if (r_state == ST_EXEC) r_jump_addr <= pc_jump_addr;
  end

  // strobes come straight off the state register so they cannot glitch
  assign imem_req  = (r_state == ST_FETCH);
  assign exu_en    = (r_state == ST_EXEC);
  assign dmem_req  = (r_state == ST_MEM);
  assign rf_we     = (r_state == ST_WB);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign halted    = r_halted;
  assign halt_code = r_halt_code;

`ifdef YSYX_22040237_PERF_EN
  logic w_inc_instret;
  logic w_freeze;

  // a halting ebreak retires; invalid and misaligned instructions do not
  assign w_inc_instret = (r_state == ST_WB) ||
                         ((r_state == ST_EXEC) && inst_ebreak && !invalid_inst);
  assign w_freeze      = (r_state == ST_HALT);

  ysyx_22040237_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .inc_cycle   (1'b1),
    .inc_instret (w_inc_instret),
    .freeze      (w_freeze),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// Directed + randomized bench for ysyx_22040237_mcyc_ctrl against an
// instruction-level reference model (expected PC, latency, halt, retire count).
module tb_ysyx_22040237_mcyc_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        exu_en;
  logic        is_mem;
  logic        jump_en;
  logic [31:0] pc_jump_addr;
  logic        inst_ebreak;
  logic        invalid_inst;
  logic        dmem_req;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;
  logic [1:0]  halt_code;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  ysyx_22040237_mcyc_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .exu_en       (exu_en),
    .is_mem       (is_mem),
    .jump_en      (jump_en),
    .pc_jump_addr (pc_jump_addr),
    .inst_ebreak  (inst_ebreak),
    .invalid_inst (invalid_inst),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .rf_we        (rf_we),
    .pc           (pc),
    .halted       (halted),
    .halt_code    (halt_code),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          tick;
  int          halt_tick;
  bit          hs;
  logic [31:0] m_pc;
  logic [1:0]  m_code;
  longint      m_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tick++;
    if (halted && !hs) begin
      hs = 1'b1;
      halt_tick = tick;
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef YSYX_22040237_PERF_EN
    chk({tag, " cycle_cnt"}, cycle_cnt, 64'(hs ? halt_tick : tick));
    chk({tag, " instret_cnt"}, instret_cnt, 64'(m_ret));
`else
    chk({tag, " counters tied"}, {cycle_cnt, instret_cnt} == 128'd0, 64'd1);
`endif
  endtask

  task automatic clear_inputs();
    imem_rvalid = 1'b0; imem_rdata = 32'd0; is_mem = 1'b0; jump_en = 1'b0;
    pc_jump_addr = 32'd0; inst_ebreak = 1'b0; invalid_inst = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick = 0; hs = 1'b0; halt_tick = 0;
    m_pc = RST_PC; m_ret = 0;
    chk("reset strobes", {imem_req, dmem_req, exu_en, rf_we, halted}, 64'd0);
    chk("reset pc", pc, RST_PC);
    chk("reset imem_addr", imem_addr, RST_PC);
    chk("reset inst", inst, 64'd0);
    chk("reset halt_code", halt_code, 64'd0);
    chk_perf("reset");
    step();
    chk("idle to fetch", imem_req, 64'd1);
  endtask

  // One instruction from its first FETCH cycle up to the next fetch (or halt).
  task automatic run_instr(input int fdly, input int mdly, input bit mem, input bit jmp,
                           input logic [31:0] tgt, input bit ebrk, input bit inv,
                           input string tag);
    int cyc = 0, fw = 0, mw = 0, nexu = 0, nmem = 0, nwe = 0, exp_cyc;
    bit got = 1'b0, hx;
    logic [1:0]  hc;
    logic [31:0] rd, exp_pc;
    hx      = inv || ebrk || (jmp && (tgt[1:0] != 2'b00));
    hc      = inv ? 2'd1 : (ebrk ? 2'd0 : 2'd2);
    exp_pc  = hx ? m_pc : (jmp ? tgt : m_pc + 32'd4);
    exp_cyc = fdly + 3 + (hx ? 0 : 1 + (mem ? mdly + 1 : 0));
    rd = $urandom;
    is_mem = mem; jump_en = jmp; pc_jump_addr = tgt; inst_ebreak = ebrk; invalid_inst = inv;
    while (!(got && (imem_req || halted)) && cyc < 300) begin
      imem_rvalid = 1'b0; imem_rdata = $urandom; dmem_ack = 1'b0;
      if (imem_req) begin
        if (fw == 0) chk({tag, " fetch addr"}, imem_addr, m_pc);
        if (fw == fdly) begin
          imem_rvalid = 1'b1; imem_rdata = rd; got = 1'b1;
        end
        fw++;
      end else begin
        imem_rvalid = 1'($urandom);
      end
      if (dmem_req) begin
        nmem++;
        if (mw == mdly) dmem_ack = 1'b1;
        mw++;
      end else begin
        dmem_ack = 1'($urandom);
      end
      if (exu_en) begin
        nexu++;
        chk({tag, " inst latched"}, inst, rd);
        chk({tag, " pc in exec"}, pc, m_pc);
      end
      if (rf_we) nwe++;
      step();
      cyc++;
    end
    clear_inputs();
    chk({tag, " latency"}, cyc, exp_cyc);
    chk({tag, " exu_en pulses"}, nexu, 64'd1);
    chk({tag, " dmem_req cycles"}, nmem, (mem && !hx) ? mdly + 1 : 0);
    chk({tag, " rf_we pulses"}, nwe, hx ? 0 : 1);
    chk({tag, " halted"}, halted, hx);
    if (hx) chk({tag, " halt_code"}, halt_code, hc);
    chk({tag, " pc after"}, pc, exp_pc);
    m_pc = exp_pc;
    if (hx) m_code = hc;
    if (!hx || (ebrk && !inv)) m_ret++;
    chk_perf(tag);
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      imem_rvalid = 1'($urandom); dmem_ack = 1'($urandom);
      step();
      chk("halt strobes", {imem_req, dmem_req, exu_en, rf_we, halted}, 64'd1);
      chk("halt pc", pc, m_pc);
      chk("halt code held", halt_code, m_code);
    end
    clear_inputs();
    chk_perf("halt hold");
  endtask

  task automatic rand_instr(input string tag);
    logic [31:0] t;
    bit j;
    t = $urandom;
    j = ($urandom_range(0, 3) == 0);
    run_instr($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom), j,
              {t[31:2], 2'b00}, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // straight-line addi stream, back-to-back fetch
    for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "addi");
    run_instr(0, 2, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "mem wait");
    run_instr(0, 0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "mem ack0");
    run_instr(1, 0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, "jump");
    run_instr(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, "jump top");
    run_instr(2, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "pc wrap");
    chk("pc wrapped", pc, 64'd0);
    for (int i = 0; i < 40; i++) rand_instr("rand");
    run_instr(0, 0, 1'b0, 1'b1, 32'h8000_0102, 1'b0, 1'b0, "misalign");
    hold_halt(20);

    do_reset();
    for (int i = 0; i < 5; i++) run_instr($urandom_range(0, 2), 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "addi5");
    run_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, "ebreak");
`ifdef YSYX_22040237_PERF_EN
    chk("ebreak instret", instret_cnt, 64'd6);
`endif
    hold_halt(100);

    do_reset();
    run_instr(1, 0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, "invalid+ebreak");
    hold_halt(100);

    // reset while a data request is outstanding
    do_reset();
    is_mem = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_2003;
    cyc = 0;
    while (!dmem_req && cyc < 20) begin step(); cyc++; end
    imem_rvalid = 1'b0;
    chk("mem reached", dmem_req, 64'd1);
    step();
    chk("mem still waiting", dmem_req, 64'd1);
    rst = 1'b1;
    step();
    chk("rst drops dmem_req", {imem_req, dmem_req, halted}, 64'd0);
    chk("rst pc", pc, RST_PC);
    rst = 1'b0; dmem_ack = 1'b1; is_mem = 1'b0;
    tick = 0; hs = 1'b0; m_pc = RST_PC; m_ret = 0;
    chk_perf("mid reset");
    step();
    chk("late ack ignored a", {imem_req, dmem_req}, 64'd2);
    step();
    chk("late ack ignored b", {imem_req, dmem_req}, 64'd2);
    dmem_ack = 1'b0;
    run_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "after mid reset");

    for (int i = 0; i < 15; i++) rand_instr("rand2");
    run_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, "rand2 ebreak");
    hold_halt(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
